// File: rtl/ysyx_24110015_branch_resolver.sv
// rtl/ysyx_24110015_branch_resolver.sv - EXU branch resolution, BTB update producer and IFU redirect source
//
// Purpose:
//   Compares the actual next PC of each resolved instruction against the PC the
//   IFU fetched after it. Emits a registered BTB update, and on a mismatch a
//   one-cycle flush plus a redirect held until the IFU accepts it. Keeps
//   saturating counts of control-flow instructions and mispredictions.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        resolved-instruction handshake (ready only in IDLE)
//   in_pc, in_pred_pc        instruction PC and the PC the IFU predicted after it
//   in_is_branch/jal/jalr    instruction kind
//   in_taken, in_target      branch outcome and computed target
//   upd_*                    registered BTB update, one cycle after accept
//   redir_valid/ready/pc     redirect request to IFU, held until accepted
//   flush                    one-cycle squash pulse on mispredict
//   cnt_cf, cnt_mispred      saturating performance counters
module ysyx_24110015_branch_resolver #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_pred_pc,
  input  logic             in_is_branch,
  input  logic             in_is_jal,
  input  logic             in_is_jalr,
  input  logic             in_taken,
  input  logic [31:0]      in_target,
  output logic             upd_valid,
  output logic             upd_branch,
  output logic             upd_jal,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic             flush,
  output logic [CNT_W-1:0] cnt_cf,
  output logic [CNT_W-1:0] cnt_mispred
);

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic        accept;
  logic        cf;
  logic        redirect_to_target;
  logic [31:0] actual;
  logic        mis;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  assign cf                 = in_is_branch | in_is_jal | in_is_jalr;
  assign redirect_to_target = in_is_jal | in_is_jalr | (in_is_branch & in_taken);
  // Fall-through add wraps modulo 2^32 so the top-of-memory PC predicts 0.
  assign actual             = redirect_to_target ? in_target : in_pc + 32'd4;
  // Non-cf instructions are checked too: a stale BTB hit must be undone.
  assign mis                = (actual != in_pred_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && mis) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir_valid && redir_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid   <= 1'b0;
      upd_branch  <= 1'b0;
      upd_jal     <= 1'b0;
      upd_pc      <= 32'd0;
      upd_target  <= 32'd0;
      flush       <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= 32'd0;
      cnt_cf      <= '0;
      cnt_mispred <= '0;
    end else begin
      // upd_* and flush are single-cycle pulses; zero unless this edge accepts.
      upd_valid  <= 1'b0;
      upd_branch <= 1'b0;
      upd_jal    <= 1'b0;
      upd_pc     <= 32'd0;
      upd_target <= 32'd0;
      flush      <= 1'b0;

      if (accept) begin
        // jalr and not-taken branches strobe with both kind bits clear so the
        // predictor sees them but installs nothing.
        upd_valid  <= cf;
        upd_branch <= in_is_branch & in_taken;
        upd_jal    <= in_is_jal;
        upd_pc     <= cf ? in_pc : 32'd0;
        upd_target <= cf ? in_target : 32'd0;
        if (mis) begin
          flush       <= 1'b1;
          redir_valid <= 1'b1;
          redir_pc    <= actual;
        end
        if (cf && cnt_cf != CNT_MAX) begin
          cnt_cf <= cnt_cf + 1'b1;
        end
        if (mis && cnt_mispred != CNT_MAX) begin
          cnt_mispred <= cnt_mispred + 1'b1;
        end
      end else if (redir_valid && redir_ready) begin
        redir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_branch_resolver.sv
// tb/tb_ysyx_24110015_branch_resolver.sv - directed scoreboard bench for the branch resolver
module tb_ysyx_24110015_branch_resolver;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_pred_pc, in_target;
  logic        in_is_branch, in_is_jal, in_is_jalr, in_taken;
  logic        redir_ready;

  logic        in_ready;
  logic        upd_valid, upd_branch, upd_jal;
  logic [31:0] upd_pc, upd_target, redir_pc;
  logic        redir_valid, flush;
  logic [31:0] cnt_cf, cnt_mispred;

  logic        s_in_ready, s_upd_valid, s_upd_branch, s_upd_jal;
  logic [31:0] s_upd_pc, s_upd_target, s_redir_pc;
  logic        s_redir_valid, s_flush;
  logic [3:0]  s_cnt_cf, s_cnt_mispred;

  ysyx_24110015_branch_resolver dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pred_pc(in_pred_pc),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_taken(in_taken), .in_target(in_target),
    .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_jal(upd_jal),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .cnt_cf(cnt_cf), .cnt_mispred(cnt_mispred)
  );

  ysyx_24110015_branch_resolver #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_pred_pc(in_pred_pc),
    .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .in_taken(in_taken), .in_target(in_target),
    .upd_valid(s_upd_valid), .upd_branch(s_upd_branch), .upd_jal(s_upd_jal),
    .upd_pc(s_upd_pc), .upd_target(s_upd_target),
    .redir_valid(s_redir_valid), .redir_ready(redir_ready), .redir_pc(s_redir_pc),
    .flush(s_flush), .cnt_cf(s_cnt_cf), .cnt_mispred(s_cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd_valid;
    logic        upd_branch;
    logic        upd_jal;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        mis;
    logic [31:0] redir_pc;
    logic [31:0] cf_cnt;
    logic [31:0] mis_cnt;
    logic [3:0]  cf_cnt4;
    logic [3:0]  mis_cnt4;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] m_cf, m_mis;
  logic [3:0]  m_cf4, m_mis4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cf = 0; m_mis = 0; m_cf4 = 0; m_mis4 = 0;
    sb.delete();
  endtask

  // Drive one accept, push the model's expectation, compare after the edge.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] pred,
                      input logic br, input logic jal, input logic jalr,
                      input logic tk, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] act;
    logic cfb;
    @(negedge clk);
    chk({tag, ".ready_before"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_pc = pc; in_pred_pc = pred; in_is_branch = br;
    in_is_jal = jal; in_is_jalr = jalr; in_taken = tk; in_target = tgt;
    cfb = br | jal | jalr;
    act = (jal | jalr | (br & tk)) ? tgt : pc + 32'd4;
    e.upd_valid  = cfb;
    e.upd_branch = br & tk;
    e.upd_jal    = jal;
    e.upd_pc     = cfb ? pc : 32'd0;
    e.upd_target = cfb ? tgt : 32'd0;
    e.mis        = (act != pred);
    e.redir_pc   = act;
    if (cfb && m_cf != 32'hFFFF_FFFF) m_cf++;
    if (e.mis && m_mis != 32'hFFFF_FFFF) m_mis++;
    if (cfb && m_cf4 != 4'hF) m_cf4++;
    if (e.mis && m_mis4 != 4'hF) m_mis4++;
    e.cf_cnt = m_cf; e.mis_cnt = m_mis; e.cf_cnt4 = m_cf4; e.mis_cnt4 = m_mis4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".upd_valid"},  {31'd0, upd_valid},  {31'd0, e.upd_valid});
      chk({tag, ".upd_branch"}, {31'd0, upd_branch}, {31'd0, e.upd_branch});
      chk({tag, ".upd_jal"},    {31'd0, upd_jal},    {31'd0, e.upd_jal});
      chk({tag, ".upd_pc"},     upd_pc,     e.upd_pc);
      chk({tag, ".upd_target"}, upd_target, e.upd_target);
      chk({tag, ".flush"},      {31'd0, flush},       {31'd0, e.mis});
      chk({tag, ".redir_valid"},{31'd0, redir_valid}, {31'd0, e.mis});
      chk({tag, ".in_ready"},   {31'd0, in_ready},    {31'd0, ~e.mis});
      if (e.mis) chk({tag, ".redir_pc"}, redir_pc, e.redir_pc);
      chk({tag, ".cnt_cf"},      cnt_cf,      e.cf_cnt);
      chk({tag, ".cnt_mispred"}, cnt_mispred, e.mis_cnt);
      chk({tag, ".cnt_cf4"},     {28'd0, s_cnt_cf},      {28'd0, e.cf_cnt4});
      chk({tag, ".cnt_mispred4"},{28'd0, s_cnt_mispred}, {28'd0, e.mis_cnt4});
    end
  endtask

  // Hold redir_ready low for 'hold' cycles with a stalled input offered, then accept.
  task automatic finish_redirect(input string tag, input int hold, input logic [31:0] exp_pc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      redir_ready = 1'b0;
      in_valid = 1'b1; in_is_branch = 1'b1; in_pc = 32'h900; in_pred_pc = 32'h0;
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, {31'd0, redir_valid}, 32'd1);
      chk({tag, ".hold_pc"},    redir_pc, exp_pc);
      chk({tag, ".hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".hold_flush"}, {31'd0, flush}, 32'd0);
      chk({tag, ".hold_cnt"},   cnt_mispred, m_mis);
    end
    @(negedge clk);
    in_valid = 1'b0;
    redir_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".rel_valid"}, {31'd0, redir_valid}, 32'd0);
    chk({tag, ".rel_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = 0; in_pred_pc = 0; in_target = 0;
    in_is_branch = 0; in_is_jal = 0; in_is_jalr = 0; in_taken = 0; redir_ready = 1'b0;
    model_reset();
    #12;
    chk("rst.in_ready",    {31'd0, in_ready}, 32'd1);
    chk("rst.upd_valid",   {31'd0, upd_valid}, 32'd0);
    chk("rst.redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst.flush",       {31'd0, flush}, 32'd0);
    chk("rst.cnt_cf",      cnt_cf, 32'd0);
    chk("rst.cnt_mispred", cnt_mispred, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step("t1", 32'h100, 32'h200, 1, 0, 0, 1, 32'h200);

    step("t2", 32'h100, 32'h200, 1, 0, 0, 0, 32'h200);
    finish_redirect("t2", 3, 32'h104);

    step("t3", 32'h40, 32'h80, 0, 0, 0, 0, 32'h0);
    finish_redirect("t3", 1, 32'h44);

    redir_ready = 1'b1;
    step("t4.jal",  32'h300, 32'h400, 0, 1, 0, 0, 32'h400);
    step("t4.jalr", 32'h400, 32'h1234, 0, 0, 1, 0, 32'h1234);
    step("t4.wrap", 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 32'h0);
    step("t4.idle", 32'h500, 32'h504, 0, 0, 0, 0, 32'h0);

    redir_ready = 1'b0;
    step("t5", 32'h600, 32'h700, 0, 0, 1, 0, 32'h800);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5.rst_valid", {31'd0, redir_valid}, 32'd0);
    chk("t5.rst_flush", {31'd0, flush}, 32'd0);
    chk("t5.rst_ready", {31'd0, in_ready}, 32'd1);
    chk("t5.rst_cnt",   cnt_mispred, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step("t5.post", 32'h100, 32'h200, 1, 0, 0, 1, 32'h200);

    for (int i = 0; i < 17; i++) begin
      step("t6", 32'h1000 + 32'(i * 8), 32'h2000, 1, 0, 0, 0, 32'h2000);
      finish_redirect("t6", 0, 32'h1004 + 32'(i * 8));
    end
    chk("t6.sat_cf4",  {28'd0, s_cnt_cf}, 32'd15);
    chk("t6.sat_mis4", {28'd0, s_cnt_mispred}, 32'd15);
    chk("t6.cf32",     cnt_cf, 32'd18);
    chk("t6.mis32",    cnt_mispred, 32'd17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_24110015_branch_resolver.md
Name: ysyx_24110015_branch_resolver

Overview:
EXU-side branch resolution unit. It is the producer end of the BTB update interface and the source of front-end redirects. For each resolved instruction it compares the actual next PC against the PC the IFU predicted. It then drives a registered BTB update, and on a mismatch it issues a flush and a held redirect to the IFU. It also keeps saturating counters of control-flow instructions and mispredictions.

Parameters:
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  EXU presents a resolved instruction
in_ready  out  1  resolver can accept (handshake completes when in_valid & in_ready)
in_pc  in  32  PC of the resolved instruction
in_pred_pc  in  32  next PC the IFU fetched after in_pc
in_is_branch  in  1  conditional branch
in_is_jal  in  1  jal
in_is_jalr  in  1  jalr
in_taken  in  1  branch outcome (ignored unless in_is_branch)
in_target  in  32  computed target address
upd_valid  out  1  BTB update strobe
upd_branch  out  1  update is a taken conditional branch
upd_jal  out  1  update is a jal
upd_pc  out  32  PC to install
upd_target  out  32  target to install
redir_valid  out  1  redirect request to IFU
redir_ready  in  1  IFU accepts redirect
redir_pc  out  32  correct fetch PC
flush  out  1  one-cycle pulse: squash younger in-flight instructions
cnt_cf  out  CNT_W  accepted control-flow instructions
cnt_mispred  out  CNT_W  accepted mispredictions

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State is IDLE and both counters are 0. Reset mid-REDIRECT abandons the redirect with no further pulses.
- FSM states: IDLE and REDIRECT. in_ready = (state == IDLE), combinational from state only.
- Accept occurs when in_valid & in_ready.
- Definitions on accept:
  - cf = is_branch | is_jal | is_jalr.
  - actual = (is_jal | is_jalr | (is_branch & taken)) ? in_target : in_pc + 4. The add is 32-bit modulo, so 0xFFFF_FFFC + 4 = 0.
  - mis = (actual != in_pred_pc). This applies to non-cf instructions too: a stale BTB hit on a non-branch redirects to pc+4.
- BTB update, one cycle after accept:
  - upd_valid = cf.
  - upd_branch = is_branch & taken.
  - upd_jal = is_jal.
  - upd_pc = in_pc, upd_target = in_target.
  - jalr and not-taken branches pulse upd_valid with both kind bits 0, so the predictor does not install them.
  - upd_* are registered and are zero in cycles without an accept.
- Mispredict, one cycle after accept:
  - flush = 1 for exactly one cycle.
  - redir_valid = 1 and redir_pc = actual.
  - State goes to REDIRECT.
- REDIRECT state:
  - redir_valid and redir_pc are held stable until redir_ready = 1.
  - The cycle with redir_valid & redir_ready returns state to IDLE, and redir_valid drops the next cycle.
  - If redir_ready is already 1 in the first redir_valid cycle, redir_valid lasts exactly one cycle.
  - No accepts occur in REDIRECT.
- A correct prediction causes no flush or redirect and stays in IDLE, so back-to-back accepts happen every cycle.
- Counters:
  - cnt_cf += cf per accept; cnt_mispred += mis per accept.
  - Both update in the same edge as the other registered outputs.
  - Both saturate at 2^CNT_W-1 with no wrap.
- The accept that causes a mispredict is itself counted. Instructions arriving during REDIRECT are stalled, not counted.
- Simultaneous events: flush, the upd_* pulse and entry to REDIRECT all occur in the same cycle. A flush is never raised while already in REDIRECT.

Test Plan:
1. Correctly predicted taken branch: pc=0x100, pred=0x200, branch, taken=1, target=0x200 -> next cycle upd_valid=1, upd_branch=1, upd_pc=0x100, upd_target=0x200; flush=0, redir_valid=0; cnt_cf=1, cnt_mispred=0; in_ready stays 1.
2. Mispredicted not-taken branch: pc=0x100, pred=0x200, taken=0 -> next cycle flush=1 (one cycle), redir_valid=1, redir_pc=0x104, upd_valid=1 with upd_branch=0. Hold redir_ready=0 for 3 cycles -> redir_pc stable and in_ready=0. Then set redir_ready=1 -> IDLE, in_ready=1; cnt_mispred=1.
3. Stale BTB hit on non-cf instruction: pc=0x40, pred=0x80, no cf flags -> upd_valid=0, flush=1, redir_pc=0x44, cnt_cf unchanged, cnt_mispred+1.
4. jal then jalr back-to-back, both correctly predicted, with redir_ready tied 1 -> upd_jal=1 for the jal, kind bits 0 for the jalr, two consecutive upd_valid pulses, no redirects. Separately, pc=0xFFFFFFFC, non-cf, pred=0 -> no redirect (wrap-around).
5. Assert rst while in REDIRECT with redir_ready=0 -> redir_valid and flush drop to 0 immediately, in_ready=1, counters 0; post-reset accepts behave as in case 1.
6. With CNT_W=4, perform 17 mispredicted branch accepts -> cnt_cf and cnt_mispred both saturate at 15.
